// File: rtl/data_memory_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// .data base address and word geometry.
package data_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;
    localparam int          WORD_BYTES        = 4;
    localparam int          DATA_W            = 8 * WORD_BYTES;
    localparam int          CNT_W             = 4;

    // Offset is (address - base) in unsigned 32-bit arithmetic, so addresses
    // below the base wrap to huge values and fall out of range as well.
    function automatic logic offset_in_range(input logic [31:0] offset, input int depth_words);
        return offset < 32'(WORD_BYTES * depth_words);
    endfunction

endpackage

// File: rtl/data_memory_mem_array.sv
// Single-port synchronous word RAM, write-first, no reset on the storage.
module mem_array
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
            rdata       <= wdata;
        end else begin
            rdata       <= mem_q[addr];
        end
    end

endmodule

// File: rtl/data_memory.sv
// Word-addressed .data responder: captures one load/store, waits LATENCY
// edges, then pulses dReady with registered read data or an error flag.
module data_memory
    import data_memory_pkg::*;
#(
    parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT,
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        dReady,
    output logic        dError,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               rd_q;
    logic               wr_q;
    logic               err_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               ready_q;
    logic               error_q;

    logic [31:0]        req_off;
    logic [IDX_W-1:0]   req_idx;
    logic               req_err;
    logic               last_wait;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_addr;
    logic [DATA_W-1:0]  ram_rdata;

    assign req_off   = dAddress - DATA_BASE;
    assign req_idx   = req_off[IDX_W+1:2];
    assign req_err   = (dAddress[1:0] != 2'b00)
                     || !offset_in_range(req_off, DEPTH_WORDS)
                     || (MemRead && MemWrite);

    assign last_wait = (state_q == ST_WAIT) && (cnt_q == '0);
    assign ram_we    = last_wait && wr_q && !err_q;

    // The RAM reads the live request index while idle and the captured index
    // afterwards, so its registered output already holds array[idx] by the
    // edge that enters RESP, even when LATENCY is 1.
    assign ram_addr  = (state_q == ST_IDLE) ? req_idx : idx_q;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (MemRead || MemWrite) begin
                        idx_q   <= req_idx;
                        wdata_q <= dWriteData;
                        rd_q    <= MemRead;
                        wr_q    <= MemWrite;
                        err_q   <= req_err;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RESP;
                        ready_q <= 1'b1;
                        error_q <= err_q;
                        // Stores leave the read-data register untouched.
                        if (err_q) begin
                            rdata_q <= '0;
                        end else if (rd_q) begin
                            rdata_q <= ram_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dReadData = rdata_q;
    assign dReady    = ready_q;
    assign dError    = error_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: four instances with different LATENCY values,
// scoreboard queue filled by the driver, emptied by a negedge monitor.
module tb_data_memory;

    localparam int          NL    = 4;
    localparam int          LATS [NL] = '{2, 1, 4, 15};
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 256;

    typedef struct packed {
        logic [7:0]  lane;
        logic [31:0] due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read  [NL];
    logic        mem_write [NL];
    logic [31:0] d_addr    [NL];
    logic [31:0] d_wdata   [NL];
    logic [31:0] d_rdata   [NL];
    logic        d_ready   [NL];
    logic        d_error   [NL];
    logic        busy      [NL];
    logic [1:0]  dbg_state [NL];

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          pulses [NL] = '{default: 0};
    exp_t        exp_q [$];
    exp_t        mon_e;

    logic [31:0] model_mem [NL][DEPTH];
    logic [31:0] model_rd  [NL];

    // ---------------- clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        data_memory #(
            .DATA_BASE   (BASE),
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (LATS[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .MemRead    (mem_read[g]),
            .MemWrite   (mem_write[g]),
            .dAddress   (d_addr[g]),
            .dWriteData (d_wdata[g]),
            .dReadData  (d_rdata[g]),
            .dReady     (d_ready[g]),
            .dError     (d_error[g]),
            .busy       (busy[g]),
            .dbg_state  (dbg_state[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model
    function automatic logic model_err(input logic [31:0] a, input logic rd, input logic wr);
        longint la;
        la = longint'(a);
        return (a % 4 != 0) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH) || (rd && wr);
    endfunction

    function automatic int model_word(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    // ---------------- driver
    task automatic issue(input int ln, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] data);
        exp_t  e;
        logic  err;
        @(negedge clk);
        mem_read[ln]  = rd;
        mem_write[ln] = wr;
        d_addr[ln]    = a;
        d_wdata[ln]   = data;
        err = model_err(a, rd, wr);
        if (err) model_rd[ln] = 32'h0;
        else if (rd) model_rd[ln] = model_mem[ln][model_word(a)];
        else model_mem[ln][model_word(a)] = data;
        e.lane = 8'(ln);
        e.due  = 32'(cyc + 1 + LATS[ln]);
        e.err  = err;
        e.data = model_rd[ln];
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        mem_read[ln]  = 1'b0;
        mem_write[ln] = 1'b0;
        repeat (LATS[ln]) @(negedge clk);
    endtask

    task automatic idle_all();
        for (int l = 0; l < NL; l++) begin
            mem_read[l]  = 1'b0;
            mem_write[l] = 1'b0;
            d_addr[l]    = 32'h0;
            d_wdata[l]   = 32'h0;
            model_rd[l]  = 32'h0;
        end
    endtask

    // ---------------- monitor
    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (rst && d_ready[l] === 1'b1) begin
                pulses[l]++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'(l), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ready_lane", 32'(l), 32'(mon_e.lane));
                    chk("ready_cycle", 32'(cyc), mon_e.due);
                    chk("dError", 32'(d_error[l]), 32'(mon_e.err));
                    chk("dReadData", d_rdata[l], mon_e.data);
                end
            end else begin
                chk("dError_without_ready", 32'(d_error[l]), 32'h0);
            end
        end
    end

    // ---------------- stimulus
    initial begin
        int c0;
        int p0;
        int kind;
        int ln;
        int w;
        logic [31:0] a;

        idle_all();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                chk("idle_busy", 32'(busy[l]), 32'h0);
                chk("idle_dReady", 32'(d_ready[l]), 32'h0);
                chk("idle_dReadData", d_rdata[l], 32'h0);
            end
        end

        // store/load and error cases on the LATENCY=2 lane
        issue(0, 1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
        issue(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
        issue(0, 1'b0, 1'b1, 32'h1001_000C, 32'h1111_2222);
        issue(0, 1'b1, 1'b0, 32'h1001_0006, 32'h0);
        issue(0, 1'b1, 1'b0, 32'h1001_0400, 32'h0);
        issue(0, 1'b1, 1'b0, 32'h1000_FFFC, 32'h0);
        issue(0, 1'b1, 1'b1, 32'h1001_0008, 32'hBADB_AD00);
        issue(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
        issue(0, 1'b1, 1'b0, 32'h1001_000C, 32'h0);

        // held request: second capture only from the IDLE cycle after RESP
        @(negedge clk);
        c0 = cyc;
        p0 = pulses[0];
        mem_read[0] = 1'b1;
        d_addr[0]   = 32'h1001_0008;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{lane: 8'd0, due: 32'(c0 + 1 + LATS[0] + k * (LATS[0] + 2)),
                              err: 1'b0, data: model_mem[0][2]});
        end
        model_rd[0] = model_mem[0][2];
        repeat (LATS[0] + 3) @(negedge clk);
        mem_read[0] = 1'b0;
        repeat (2 * (LATS[0] + 2) - (LATS[0] + 2)) @(negedge clk);
        chk("held_pulse_count", 32'(pulses[0] - p0), 32'd2);
        chk("held_idle_after", 32'(busy[0]), 32'h0);

        // reset in the middle of a store
        issue(0, 1'b0, 1'b1, 32'h1001_0010, 32'h0);
        @(negedge clk);
        mem_write[0] = 1'b1;
        d_addr[0]    = 32'h1001_0010;
        d_wdata[0]   = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy[0]), 32'h1);
        #2 rst = 1'b0;
        #1;
        mem_write[0] = 1'b0;
        chk("reset_busy", 32'(busy[0]), 32'h0);
        chk("reset_dReady", 32'(d_ready[0]), 32'h0);
        chk("reset_state", 32'(dbg_state[0]), 32'h0);
        chk("reset_dReadData", d_rdata[0], 32'h0);
        idle_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(0, 1'b1, 1'b0, 32'h1001_0010, 32'h0);

        // latency sweep on the other lanes
        for (int l = 1; l < NL; l++) begin
            issue(l, 1'b0, 1'b1, BASE, 32'hA5A5_A5A5);
            issue(l, 1'b1, 1'b0, BASE, 32'h0);
        end

        // randomized traffic over a 16-word window of every lane
        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < 16; i++) issue(l, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom());
        end
        for (int n = 0; n < 150; n++) begin
            ln   = $urandom_range(0, NL - 1);
            kind = $urandom_range(0, 9);
            w    = $urandom_range(0, 15);
            a    = BASE + 32'(4 * w);
            case (kind)
                0: issue(ln, 1'b1, 1'b0, a + 32'($urandom_range(1, 3)), 32'h0);
                1: issue(ln, 1'b0, 1'b1, BASE + 32'(4 * DEPTH) + 32'(4 * w), $urandom());
                2: issue(ln, 1'b1, 1'b0, BASE - 32'(4 * (w + 1)), 32'h0);
                3: issue(ln, 1'b1, 1'b1, a, $urandom());
                4, 5, 6: issue(ln, 1'b1, 1'b0, a, 32'h0);
                default: issue(ln, 1'b0, 1'b1, a, $urandom());
            endcase
        end

        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
